// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state encoding and the round helper functions.
// SHA256_DOUBLE_HASH_EN adds the S_DBL_LOAD state used by the double-hash path.
package sha256_pkg;

   localparam logic [255:0] SHA_IV =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

   localparam logic [31:0] SHA_K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ROUND    = 3'd1,
      S_FINAL    = 3'd2,
`ifdef SHA256_DOUBLE_HASH_EN
      S_DBL_LOAD = 3'd3,
`endif
      S_DONE     = 3'd4
   } sha_state_e;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working variables a..h packed with a in [255:224].
module sha256_round
   import sha256_pkg::*;
(
   input  logic [255:0] cur,
   input  logic [31:0]  wt,
   input  logic [31:0]  kt,
   output logic [255:0] nxt
);

   logic [31:0] a, b, c, d, e, f, g, h, t1, t2;

   assign {a, b, c, d, e, f, g, h} = cur;
   assign t1  = h + big_sigma1(e) + ch(e, f, g) + kt + wt;
   assign t2  = big_sigma0(a) + maj(a, b, c);
   assign nxt = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream.sv
// Multi-block SHA-256 engine, ROUNDS_PER_CYCLE rounds per clock, chained state.
// Defining SHA256_DOUBLE_HASH_EN compiles in the in_double / DBL_LOAD path.
module sha256_stream
   import sha256_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] in_block,
   input  logic         in_first,
   input  logic         in_last,
   input  logic         in_double,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_digest,
   output logic [2:0]   dbg_state
);

   localparam int R = ROUNDS_PER_CYCLE;
   localparam logic [5:0] LAST_CNT = 6'(64 - R);
   localparam logic [5:0] CNT_STEP = 6'(R);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // valid never waits on ready, and a producer holds its data until the transfer.
   sha_state_e   state_q, state_d;
   logic         in_ready_q, accept, last_q;
   logic [5:0]   cnt_q;
   logic [255:0] work_q, chain_q, digest_q, sum;
   logic [511:0] load_blk;
   logic [31:0]  w_q   [16];
   logic [31:0]  w_ext [16 + R];
   logic [255:0] rnd_st [R + 1];

   assign accept     = in_valid & in_ready_q;
   assign in_ready   = in_ready_q;
   assign out_valid  = (state_q == S_DONE);
   assign out_digest = digest_q;
   assign dbg_state  = state_q;

`ifdef SHA256_DOUBLE_HASH_EN
   logic dbl_q;
   assign load_blk = (state_q == S_DBL_LOAD) ? {chain_q, 1'b1, 191'b0, 64'd256} : in_block;
`else
   logic unused_double;
   assign unused_double = in_double;
   assign load_blk      = in_block;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d == S_IDLE);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_ROUND;
         S_ROUND: if (cnt_q == LAST_CNT) state_d = S_FINAL;
         S_FINAL: begin
            state_d = last_q ? S_DONE : S_IDLE;
`ifdef SHA256_DOUBLE_HASH_EN
            if (last_q && dbl_q) state_d = S_DBL_LOAD;
`endif
         end
`ifdef SHA256_DOUBLE_HASH_EN
         S_DBL_LOAD: state_d = S_ROUND;
`endif
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Sliding 16-word window: W[t..t+15] plus the R words that follow it.
   always_comb begin
      for (int i = 0; i < 16; i++) w_ext[i] = w_q[i];
      for (int i = 0; i < R; i++)
         w_ext[16 + i] = small_sigma1(w_ext[14 + i]) + w_ext[9 + i]
                       + small_sigma0(w_ext[1 + i]) + w_ext[i];
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < 8; i++)
         sum[255 - 32*i -: 32] = chain_q[255 - 32*i -: 32] + work_q[255 - 32*i -: 32];
   end

   assign rnd_st[0] = work_q;
   for (genvar r = 0; r < R; r++) begin : g_round
      sha256_round u_round (
         .cur (rnd_st[r]),
         .wt  (w_q[r]),
         .kt  (SHA_K[cnt_q + 6'(r)]),
         .nxt (rnd_st[r + 1])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain_q  <= SHA_IV;
         work_q   <= '0;
         digest_q <= '0;
         cnt_q    <= '0;
         last_q   <= 1'b0;
`ifdef SHA256_DOUBLE_HASH_EN
         dbl_q    <= 1'b0;
`endif
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin
               for (int i = 0; i < 16; i++) w_q[i] <= load_blk[511 - 32*i -: 32];
               // chain_q doubles as the feed-forward base, so a fresh message reloads it
               work_q <= in_first ? SHA_IV : chain_q;
               if (in_first) chain_q <= SHA_IV;
               last_q <= in_last;
               cnt_q  <= '0;
`ifdef SHA256_DOUBLE_HASH_EN
               dbl_q  <= in_double;
`endif
            end
            S_ROUND: begin
               work_q <= rnd_st[R];
               for (int i = 0; i < 16; i++) w_q[i] <= w_ext[i + R];
               cnt_q  <= cnt_q + CNT_STEP;
            end
            S_FINAL: begin
               chain_q <= sum;
               if (state_d == S_DONE) digest_q <= sum;
            end
`ifdef SHA256_DOUBLE_HASH_EN
            S_DBL_LOAD: begin
               for (int i = 0; i < 16; i++) w_q[i] <= load_blk[511 - 32*i -: 32];
               work_q  <= SHA_IV;
               chain_q <= SHA_IV;
               dbl_q   <= 1'b0;
               cnt_q   <= '0;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_stream.sv
// Bench for sha256_stream: known-answer vectors, latency/handshake/reset checks and
// random multi-block messages scored against a block-level SHA-256 model.
module tb_sha256_stream;

   localparam int N = 64;
   localparam logic [255:0] IV =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [511:0] TWO_B1 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
      32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};

   localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] DBL_DIG   = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;

   // ---------------- clock / reset and DUT wiring ----------------
   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_valid, in_first, in_last, in_double, out_ready;
   logic [511:0] in_block;
   logic         in_ready, out_valid;
   logic [255:0] out_digest;
   logic [2:0]   dbg_state;

   logic         aux_valid, aux_out_ready;
   logic [2:0]   aux_in_ready, aux_out_valid;
   logic [255:0] aux_digest [3];
   logic [2:0]   aux_dbg [3];

   always #5 clk = ~clk;

   sha256_stream #(.ROUNDS_PER_CYCLE(1)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_block   (in_block),
      .in_first   (in_first),
      .in_last    (in_last),
      .in_double  (in_double),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_digest (out_digest),
      .dbg_state  (dbg_state)
   );

   for (genvar g = 0; g < 3; g++) begin : g_aux
      sha256_stream #(.ROUNDS_PER_CYCLE(2 << g)) u_dut (
         .clk        (clk),
         .reset_n    (reset_n),
         .in_valid   (aux_valid),
         .in_ready   (aux_in_ready[g]),
         .in_block   (EMPTY_BLK),
         .in_first   (1'b1),
         .in_last    (1'b1),
         .in_double  (1'b0),
         .out_valid  (aux_out_valid[g]),
         .out_ready  (aux_out_ready),
         .out_digest (aux_digest[g]),
         .dbg_state  (aux_dbg[g])
      );
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0]  w [64];
      logic [31:0]  v [8];
      logic [31:0]  t1, t2, s0, s1;
      logic [255:0] hout;
      for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0   = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
         s1   = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      hout = '0;
      for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
      return hout;
   endfunction

   // ---------------- scoreboard and checkers ----------------
   logic [255:0] exp_q [$];
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check_bit(input string tag, input logic obs, input logic want);
      n_cmp++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, want);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int want);
      n_cmp++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask

   task automatic check_dig(input string tag, input logic [255:0] obs, input logic [255:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_block(input logic [511:0] blk, input logic first, input logic last, input logic dbl);
      int waited;
      waited = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      check_bit("in_ready_before_send", in_ready, 1'b1);
      in_valid  = 1'b1;
      in_block  = blk;
      in_first  = first;
      in_last   = last;
      in_double = dbl;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      in_double = 1'b0;
   endtask

   // Cycles from the accepting edge until out_valid is seen; returns at a negedge.
   task automatic wait_out(input int budget, output int lat);
      lat = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && lat < budget) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic take_out(input string tag);
      logic [255:0] want;
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 256'h0;
      check_dig(tag, out_digest, want);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic wait_idle(output int low);
      low = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && low < 300) begin
         low++;
         @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish (state %0d, aux %0d)", dbg_state, aux_dbg[0]);
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed and random sequence ----------------
   initial begin
      int lat, low, nb, exp_lat;
      int aux_lat [3];
      logic dbl;
      logic [255:0] h;
      logic [511:0] blk;

      reset_n = 1'b0;
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_double = 1'b0;
      in_block = '0; out_ready = 1'b0; aux_valid = 1'b0; aux_out_ready = 1'b0;

      repeat (3) @(negedge clk);
      check_bit("reset_in_ready", in_ready, 1'b0);
      check_bit("reset_out_valid", out_valid, 1'b0);
      check_dig("reset_out_digest", out_digest, 256'h0);
      reset_n = 1'b1;
      #1 check_bit("in_ready_before_first_edge", in_ready, 1'b0);
      @(negedge clk);
      check_bit("in_ready_after_first_edge", in_ready, 1'b1);

      // Empty message on the 2/4/8 rounds-per-cycle engines in parallel.
      aux_valid = 1'b1;
      for (int g = 0; g < 3; g++) begin
         check_bit("aux_in_ready", aux_in_ready[g], 1'b1);
         aux_lat[g] = 0;
      end
      @(posedge clk);
      #1 aux_valid = 1'b0;
      for (int c = 1; c <= 45; c++) begin
         @(posedge clk);
         @(negedge clk);
         for (int g = 0; g < 3; g++)
            if (aux_out_valid[g] === 1'b1 && aux_lat[g] == 0) aux_lat[g] = c;
      end
      for (int g = 0; g < 3; g++) begin
         check_int("aux_latency", aux_lat[g], 64 / (2 << g) + 1);
         check_dig("aux_empty_digest", aux_digest[g], EMPTY_DIG);
      end
      aux_out_ready = 1'b1;
      @(posedge clk);
      #1 aux_out_ready = 1'b0;

      // "abc", single block.
      exp_q.push_back(ABC_DIG);
      send_block(ABC_BLK, 1'b1, 1'b1, 1'b0);
      wait_out(200, lat);
      check_int("abc_latency", lat, N + 1);
      take_out("abc_digest");

      // Empty message, single block.
      exp_q.push_back(EMPTY_DIG);
      send_block(EMPTY_BLK, 1'b1, 1'b1, 1'b0);
      wait_out(200, lat);
      check_int("empty_latency", lat, N + 1);
      take_out("empty_digest");

      // Two-block message with chained state.
      exp_q.push_back(TWO_DIG);
      send_block(TWO_B1, 1'b1, 1'b0, 1'b0);
      wait_idle(low);
      check_int("two_block_ready_gap", low, N + 1);
      send_block(TWO_B2, 1'b0, 1'b1, 1'b0);
      wait_out(200, lat);
      check_int("two_block_latency", lat, N + 1);
      take_out("two_block_digest");

      // Double hash request on "abc".
`ifdef SHA256_DOUBLE_HASH_EN
      exp_q.push_back(DBL_DIG);
      send_block(ABC_BLK, 1'b1, 1'b1, 1'b1);
      wait_out(400, lat);
      check_int("double_latency", lat, 2 * N + 3);
`else
      exp_q.push_back(ABC_DIG);
      send_block(ABC_BLK, 1'b1, 1'b1, 1'b1);
      wait_out(400, lat);
      check_int("double_ignored_latency", lat, N + 1);
`endif
      take_out("double_digest");

      // Back-pressure: hold the digest for 20 cycles, then release it.
      send_block(EMPTY_BLK, 1'b1, 1'b1, 1'b0);
      wait_out(200, lat);
      for (int c = 0; c < 20; c++) begin
         check_bit("hold_out_valid", out_valid, 1'b1);
         check_dig("hold_out_digest", out_digest, EMPTY_DIG);
         check_bit("hold_in_ready", in_ready, 1'b0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check_bit("release_in_ready", in_ready, 1'b1);
      check_bit("release_out_valid", out_valid, 1'b0);

      // Random multi-block messages, random gaps, stray out_ready during non-final blocks.
      for (int m = 0; m < 6; m++) begin
         nb  = $urandom_range(1, 3);
         dbl = 1'($urandom_range(0, 1));
         h   = IV;
         for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 16; k++) blk[511 - 32*k -: 32] = $urandom();
            h = compress(h, blk);
            out_ready = (b < nb - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_block(blk, b == 0, b == nb - 1, dbl);
         end
         exp_lat = N + 1;
`ifdef SHA256_DOUBLE_HASH_EN
         if (dbl) begin
            h = compress(IV, {h, 1'b1, 191'b0, 64'd256});
            exp_lat = 2 * N + 3;
         end
`endif
         exp_q.push_back(h);
         wait_out(400, lat);
         check_int("rand_latency", lat, exp_lat);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         take_out("rand_digest");
      end

      // Reset in the middle of a continuation block; the chain must return to IV.
      send_block(TWO_B1, 1'b1, 1'b0, 1'b0);
      wait_idle(low);
      send_block(TWO_B2, 1'b0, 1'b0, 1'b0);
      repeat (30) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check_bit("async_reset_in_ready", in_ready, 1'b0);
      check_bit("async_reset_out_valid", out_valid, 1'b0);
      check_dig("async_reset_out_digest", out_digest, 256'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (70) @(negedge clk);
      check_bit("no_digest_after_reset", out_valid, 1'b0);
      exp_q.push_back(ABC_DIG);
      send_block(ABC_BLK, 1'b0, 1'b1, 1'b0);
      wait_out(200, lat);
      check_int("post_reset_latency", lat, N + 1);
      take_out("post_reset_abc_from_iv");

      check_int("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
